// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI register responder.
package spi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StCmd,
    StData
  } spi_state_e;

  localparam int unsigned CMD_RW_BIT = 7;
  localparam int unsigned BYTE_BITS  = 8;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin, with rise/fall detect on the synced level.
module spi_sync_edge #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      meta_q <= RESET_VAL;
      sync_q <= RESET_VAL;
      prev_q <= RESET_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
      prev_q <= sync_q;
    end
  end

  assign q_o    = sync_q;
  assign rise_o = sync_q & ~prev_q;
  assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_reg_responder.sv
// SPI mode-0 responder exposing a byte-wide register file, with a parallel host port.
// Frame: command byte (RW + start address) followed by auto-incrementing data bytes.
module spi_reg_responder
  import spi_pkg::*;
#(
  parameter int unsigned NUM_REGS = 8,
  parameter int unsigned ADDR_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic              mosi,
  output logic              miso,
  output logic              miso_oe,
  input  logic              sys_we,
  input  logic [ADDR_W-1:0] sys_addr,
  input  logic [7:0]        sys_wdata,
  output logic [7:0]        sys_rdata,
  output logic              spi_wr_pulse,
  output logic              frame_done,
  output logic              frame_err
);

  localparam int unsigned CNT_W = $clog2(BYTE_BITS);

  logic unused_sclk_level;
  logic sclk_rise;
  logic sclk_fall;
  logic cs_n_s;
  logic cs_rise;
  logic cs_fall;

  spi_sync_edge #(
    .RESET_VAL (1'b0)
  ) u_sync_sclk (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (sclk),
    .q_o    (unused_sclk_level),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  // Reset high so a held-low cs_n does not look like an active frame during reset.
  spi_sync_edge #(
    .RESET_VAL (1'b1)
  ) u_sync_cs (
    .clk_i  (clk),
    .rst_i  (rst),
    .d_i    (cs_n),
    .q_o    (cs_n_s),
    .rise_o (cs_rise),
    .fall_o (cs_fall)
  );

  logic mosi_meta_q;
  logic mosi_s;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mosi_meta_q <= 1'b0;
      mosi_s      <= 1'b0;
    end else begin
      mosi_meta_q <= mosi;
      mosi_s      <= mosi_meta_q;
    end
  end

  spi_state_e        state_q, state_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [6:0]        rx_q, rx_d;
  logic [7:0]        tx_q, tx_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              rw_q, rw_d;
  logic              got_byte_q, got_byte_d;
  logic              armed_q, armed_d;
  logic [1:0]        settle_q;
  logic              wr_pulse_q, wr_pulse_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic [7:0]        regs_q [NUM_REGS];

  logic              spi_we;
  logic [7:0]        rx_byte;
  logic [ADDR_W-1:0] cmd_addr;
  logic [ADDR_W-1:0] addr_inc;
  logic              last_bit;

  assign rx_byte  = {rx_q, mosi_s};
  assign cmd_addr = rx_byte[ADDR_W-1:0];
  assign addr_inc = addr_q + ADDR_W'(1);
  assign last_bit = (bit_cnt_q == CNT_W'(BYTE_BITS - 1));

  always_comb begin
    state_d    = state_q;
    bit_cnt_d  = bit_cnt_q;
    rx_d       = rx_q;
    tx_d       = tx_q;
    addr_d     = addr_q;
    rw_d       = rw_q;
    got_byte_d = got_byte_q;
    wr_pulse_d = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    spi_we     = 1'b0;
    // Arm only once the synchronizer holds real pin samples showing cs_n high.
    armed_d    = armed_q | (settle_q[1] & cs_n_s);

    unique case (state_q)
      StIdle: begin
        if (cs_fall && armed_q) begin
          state_d    = StCmd;
          bit_cnt_d  = '0;
          rx_d       = '0;
          rw_d       = 1'b0;
          got_byte_d = 1'b0;
        end
      end
      StCmd, StData: begin
        if (sclk_rise) begin
          rx_d      = rx_byte[6:0];
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          if (last_bit) begin
            if (state_q == StCmd) begin
              state_d    = StData;
              rw_d       = rx_byte[CMD_RW_BIT];
              addr_d     = cmd_addr;
              got_byte_d = 1'b1;
              if (rx_byte[CMD_RW_BIT]) begin
                tx_d = regs_q[cmd_addr];
              end
            end else begin
              addr_d = addr_inc;
              if (rw_q) begin
                tx_d = regs_q[addr_inc];
              end else begin
                spi_we     = 1'b1;
                wr_pulse_d = 1'b1;
              end
            end
          end
        end else if (sclk_fall && state_q == StData && rw_q && bit_cnt_q != '0) begin
          // The fall right after a byte boundary keeps the freshly loaded MSB on the line.
          tx_d = {tx_q[6:0], 1'b0};
        end

        if (cs_rise) begin
          state_d    = StIdle;
          bit_cnt_d  = '0;
          spi_we     = 1'b0;
          wr_pulse_d = 1'b0;
          if (bit_cnt_q != '0) begin
            err_d = 1'b1;
          end else if (got_byte_q) begin
            done_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      bit_cnt_q  <= '0;
      rx_q       <= '0;
      tx_q       <= '0;
      addr_q     <= '0;
      rw_q       <= 1'b0;
      got_byte_q <= 1'b0;
      armed_q    <= 1'b0;
      settle_q   <= '0;
      wr_pulse_q <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_q       <= rx_d;
      tx_q       <= tx_d;
      addr_q     <= addr_d;
      rw_q       <= rw_d;
      got_byte_q <= got_byte_d;
      armed_q    <= armed_d;
      settle_q   <= {settle_q[0], 1'b1};
      wr_pulse_q <= wr_pulse_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  // SPI write takes priority over a host write to the same register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (spi_we && addr_q == ADDR_W'(i)) begin
          regs_q[i] <= rx_byte;
        end else if (sys_we && sys_addr == ADDR_W'(i)) begin
          regs_q[i] <= sys_wdata;
        end
      end
    end
  end

  assign sys_rdata    = regs_q[sys_addr];
  assign miso_oe      = ~cs_n_s;
  assign miso         = (~cs_n_s && state_q == StData && rw_q) ? tx_q[7] : 1'b0;
  assign spi_wr_pulse = wr_pulse_q;
  assign frame_done   = done_q;
  assign frame_err    = err_q;

endmodule

// File: doc/spi_reg_responder.md
Name: spi_reg_responder

Overview:
SPI mode-0 responder that presents a small byte-wide register file to an SPI master. SCK, CS_N and MOSI are oversampled in the system clock domain, and frames are decoded as a command byte followed by data bytes. The host side has a parallel read/write port into the same registers. It sits on the slave side of the SPI wrapper and replaces the plain shift-register slave where addressed access is needed.

Parameters:
NUM_REGS, 8, number of 8-bit registers; must be a power of 2, maximum 128
ADDR_W, $clog2(NUM_REGS), width of the register address

Ports:
clk  input  1  system clock; must be at least 8x the SCK frequency
rst  input  1  asynchronous, active-high reset
sclk  input  1  SPI clock from master, asynchronous to clk
cs_n  input  1  chip select, active low, asynchronous
mosi  input  1  serial data in, asynchronous
miso  output  1  serial data out
miso_oe  output  1  miso drive enable; the wrapper tri-states miso when this is 0
sys_we  input  1  host write strobe
sys_addr  input  ADDR_W  host register address
sys_wdata  input  8  host write data
sys_rdata  output  8  combinational read of reg[sys_addr]
spi_wr_pulse  output  1  one-cycle pulse on each SPI register write
frame_done  output  1  one-cycle pulse when CS_N rises after a byte-aligned frame
frame_err  output  1  one-cycle pulse when CS_N rises mid-byte

Behaviour:
- Reset (async, active-high):
  - all registers are 0x00; miso=0, miso_oe=0; all pulses are 0
  - state is IDLE; bit counter and shift registers are cleared
- Input sync:
  - 2-FF synchronizers on sclk, cs_n and mosi, then edge detect on synced sclk
  - latency from a pin edge to its internal event is 2-3 clk cycles
- Frame format (MSB first, mode 0: sample on SCK rise, shift on SCK fall):
  - byte0 is the command: bit7 = RW (1 = read); bits[ADDR_W-1:0] = start address; other bits are ignored
  - bytes 1..n are data; the address auto-increments after each data byte and wraps modulo NUM_REGS
- State machine (IDLE, CMD, DATA):
  - IDLE -> CMD on synced cs_n falling; bit_cnt=0
  - CMD: shift mosi in on each sclk rise. On the 8th rise, latch RW and address and go to DATA.
    - If RW=1, load tx_shift=reg[addr] in the same cycle.
  - DATA write: on the 8th rise of a byte, reg[addr] <= rx byte; spi_wr_pulse=1 in the next cycle; addr++.
  - DATA read:
    - miso is the MSB of tx_shift; tx_shift shifts on each sclk fall
    - on the 8th rise, addr++ and tx_shift reloads from reg[addr+1] before the next fall
  - any state -> IDLE on synced cs_n rising:
    - frame_done if bit_cnt==0 and at least one byte was received
    - frame_err if bit_cnt!=0; the partial byte is discarded and no write occurs
- miso_oe equals !cs_n_sync; miso is 0 whenever miso_oe=0 and during CMD.
- Simultaneous SPI write and sys_we to the same address in the same cycle: the SPI write wins. Different addresses: both commit.
- sclk edges while cs_n is high are ignored.
- A cs_n glitch shorter than the sync depth is not guaranteed to be seen.
- Reset mid-frame aborts immediately with no pulses. After reset release the block waits for a fresh cs_n falling edge; if cs_n is already low, it waits for cs_n high then low.

Decomposition:
- Shared package spi_pkg holds:
  - the state enum typedef (IDLE, CMD, DATA)
  - constant CMD_RW_BIT=7
  - constant BYTE_BITS=8
- Sub-module spi_sync_edge: 2-FF synchronizer plus rise/fall detect. Instantiated for sclk and cs_n; the synchronizer alone is used for mosi.

Test Plan:
- Write: cmd 0x02, data 0xA5 -> reg[2]=0xA5; one spi_wr_pulse; frame_done; sys_rdata@2=0xA5.
- Read: sys write reg[5]=0x3C; then cmd 0x85 -> MISO bits 0,0,1,1,1,1,0,0 sampled on SCK rise; miso_oe high only while cs_n low.
- Burst wrap: cmd 0x07, data 0x11,0x22,0x33 -> reg[7]=0x11, reg[0]=0x22, reg[1]=0x33; three spi_wr_pulse.
- Abort: cmd 0x03 then 5 bits of data 0xFF, cs_n high -> frame_err=1; reg[3] unchanged; no spi_wr_pulse.
- Collision: SPI write 0x55 to reg[4] while sys_we writes 0xAA to reg[4] in the commit cycle -> reg[4]=0x55.
- Reset mid-frame: assert rst after 12 bits -> all regs 0, miso_oe=0; the next full frame (cmd 0x01, data 0x99) sets reg[1]=0x99.
